// File: rtl/gate_gen_pkg.sv
// Shared definitions for the gate/test-signal generator.
//   gate_state_e       : FSM state encoding (StIdle, StRun)
//   GATE_MIN_PERIOD    : smallest period accepted after clamping
//   GATE_DEFAULT_WIDTH : default width of period/high/counter registers
package gate_gen_pkg;

    localparam int unsigned GATE_DEFAULT_WIDTH = 32;
    localparam int unsigned GATE_MIN_PERIOD    = 2;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } gate_state_e;

endpackage

// File: rtl/gate_cfg_buf.sv
// Pending/active double buffer for the gate generator configuration.
// A word accepted on the cfg port is clamped and parked in the pending
// registers; the FSM's promote strobe copies it into the active registers.
// Ports:
//   sys_count_clk, rst_n       : clock, async active-low reset
//   cfg_valid/cfg_ready        : valid/ready handshake for a config word
//   cfg_period, cfg_high       : raw period / high time (clock cycles)
//   promote                    : copy pending -> active this cycle
//   pend_vld, pend_period/high : pending buffer state
//   act_vld, act_period/high   : active buffer state
module gate_cfg_buf
    import gate_gen_pkg::*;
#(
    parameter int unsigned WIDTH = GATE_DEFAULT_WIDTH
) (
    input  logic             sys_count_clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             promote,
    output logic             pend_vld,
    output logic [WIDTH-1:0] pend_period,
    output logic [WIDTH-1:0] pend_high,
    output logic             act_vld,
    output logic [WIDTH-1:0] act_period,
    output logic [WIDTH-1:0] act_high
);

    localparam logic [WIDTH-1:0] MinPeriod = WIDTH'(GATE_MIN_PERIOD);
    localparam logic [WIDTH-1:0] One       = WIDTH'(1);

    logic             pend_vld_q;
    logic [WIDTH-1:0] pend_period_q;
    logic [WIDTH-1:0] pend_high_q;
    logic             act_vld_q;
    logic [WIDTH-1:0] act_period_q;
    logic [WIDTH-1:0] act_high_q;

    logic             xfer;
    logic [WIDTH-1:0] clamp_period;
    logic [WIDTH-1:0] clamp_high;

    assign cfg_ready = !pend_vld_q;
    assign xfer      = cfg_valid && !pend_vld_q;

    // High time may be zero but never reaches the full period, so the gate
    // always has at least one low cycle per period.
    always_comb begin
        clamp_period = (cfg_period < MinPeriod) ? MinPeriod : cfg_period;
        clamp_high   = (cfg_high > (clamp_period - One)) ? (clamp_period - One) : cfg_high;
    end

    // promote is only raised while pend_vld_q is set, and a transfer needs it
    // clear, so the two branches never compete.
    always_ff @(posedge sys_count_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q    <= 1'b0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            act_vld_q     <= 1'b0;
            act_period_q  <= '0;
            act_high_q    <= '0;
        end else if (promote) begin
            act_period_q <= pend_period_q;
            act_high_q   <= pend_high_q;
            act_vld_q    <= 1'b1;
            pend_vld_q   <= 1'b0;
        end else if (xfer) begin
            pend_period_q <= clamp_period;
            pend_high_q   <= clamp_high;
            pend_vld_q    <= 1'b1;
        end
    end

    assign pend_vld    = pend_vld_q;
    assign pend_period = pend_period_q;
    assign pend_high   = pend_high_q;
    assign act_vld     = act_vld_q;
    assign act_period  = act_period_q;
    assign act_high    = act_high_q;

endmodule

// File: rtl/gate_pulse_gen.sv
// Programmable periodic gate generator for the gated period counter.
// Settings are double-buffered and only take effect on period boundaries.
// Optional feature: define GATE_PULSE_GEN_PCNT_EN to add period_count, a
// free-running count of completed periods (cleared only by reset).
// Ports:
//   sys_count_clk, rst_n   : clock, async active-low reset
//   cfg_valid/cfg_ready    : config handshake
//   cfg_period, cfg_high   : period and high time in clock cycles
//   en                     : run request
//   gate_out               : registered gate output
//   period_tick            : high on the last cycle of each period
//   period_count           : completed periods (GATE_PULSE_GEN_PCNT_EN only)
//   busy                   : generator is running
module gate_pulse_gen
    import gate_gen_pkg::*;
#(
    parameter int unsigned WIDTH = GATE_DEFAULT_WIDTH
) (
    input  logic             sys_count_clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             en,
    output logic             gate_out,
    output logic             period_tick,
`ifdef GATE_PULSE_GEN_PCNT_EN
    output logic [WIDTH-1:0] period_count,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    gate_state_e      state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             gate_q;

    logic             promote;
    logic             pend_vld;
    logic [WIDTH-1:0] pend_period;
    logic [WIDTH-1:0] pend_high;
    logic             act_vld;
    logic [WIDTH-1:0] act_period;
    logic [WIDTH-1:0] act_high;

    logic             wrap;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] high_next;

    gate_cfg_buf #(
        .WIDTH (WIDTH)
    ) u_cfg_buf (
        .sys_count_clk (sys_count_clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_high      (cfg_high),
        .promote       (promote),
        .pend_vld      (pend_vld),
        .pend_period   (pend_period),
        .pend_high     (pend_high),
        .act_vld       (act_vld),
        .act_period    (act_period),
        .act_high      (act_high)
    );

    // pend_period is only consumed through the buffer's promotion path.
    logic unused_pend_period;
    assign unused_pend_period = ^pend_period;

    always_comb begin
        wrap    = (cnt_q == (act_period - One));
        cnt_inc = cnt_q + One;
        if (state_q == StIdle) begin
            promote = pend_vld;
        end else begin
            promote = wrap && pend_vld;
        end
        // The period that starts after this edge uses the freshly promoted
        // high time when a promotion coincides with it.
        high_next = promote ? pend_high : act_high;
    end

    always_ff @(posedge sys_count_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en && act_vld) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        gate_q  <= (high_next != '0);
                    end
                end
                StRun: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (en) begin
                            gate_q <= (high_next != '0);
                        end else begin
                            state_q <= StIdle;
                            gate_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q  <= cnt_inc;
                        gate_q <= (cnt_inc < act_high);
                    end
                end
            endcase
        end
    end

    assign gate_out    = gate_q;
    assign busy        = (state_q == StRun);
    assign period_tick = (state_q == StRun) && wrap;

`ifdef GATE_PULSE_GEN_PCNT_EN
    logic [WIDTH-1:0] pcnt_q;

    always_ff @(posedge sys_count_clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else if (period_tick) begin
            pcnt_q <= pcnt_q + One;
        end
    end

    assign period_count = pcnt_q;
`endif

endmodule

// File: doc/gate_pulse_gen.md
# gate_pulse_gen

Programmable gate/test-signal generator for the frequency-measurement path. It produces a periodic rectangular gate whose period and high time are set in `sys_count_clk` cycles through a valid/ready config port. It drives the gate input of the gated period counter, and serves as its stimulus source in loop-back self-test. New settings are double-buffered and applied only on period boundaries, so the counter never sees a truncated period.

## Interface
- `WIDTH`, 32: width of the period, high-time and internal counters.
- `sys_count_clk` in 1: sole clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: a config word is offered.
- `cfg_ready` out 1: the pending buffer is free; transfer when `cfg_valid & cfg_ready`.
- `cfg_period` in WIDTH: period in clock cycles.
- `cfg_high` in WIDTH: high time in clock cycles.
- `en` in 1: run request.
- `gate_out` out 1: generated gate, registered.
- `period_tick` out 1: one-cycle pulse on the last cycle of each period.
- `busy` out 1: state is RUN.

## Operation
- **Config transfer:** the accepted word goes to the pending registers (`pend_period`, `pend_high`) and sets `pend_vld`.
  - `cfg_ready = !pend_vld`.
- **Clamping on transfer:**
  - period < 2 becomes 2.
  - high > period-1 becomes period-1.
  - high = 0 is legal: the gate stays low for the whole period.
- **Promotion:** pending is promoted to active (`act_period`, `act_high`) and `pend_vld` is cleared:
  - in IDLE, on the cycle after the transfer;
  - in RUN, on the wrap cycle (cnt = act_period-1), only if `pend_vld` was already set at the start of that cycle.
  - A transfer during a wrap cycle is applied at the following wrap.
- **States:** IDLE and RUN.
  - IDLE → RUN when `en=1` and `act_vld=1`. `act_vld` is set on the first promotion and cleared only by reset. cnt is set to 0.
  - RUN → IDLE on the wrap cycle if `en=0`. A period in progress always completes.
  - If `en` goes high again before the wrap, RUN continues with no gap.
- **Counting:** in RUN, cnt counts 0..act_period-1, then wraps to 0.
  - `gate_out` is registered as (next cnt < act_high).
  - `gate_out` is high for exactly act_high cycles, then low for act_period-act_high cycles.
- **`period_tick`:** equals 1 exactly when cnt = act_period-1 in RUN.
- **In IDLE:** `gate_out=0` and `period_tick=0`.
- **Arithmetic:** all of it is unsigned WIDTH-bit. cnt never exceeds act_period-1, so it never overflows.

## Timing
- **Reset values:**
  - `gate_out=0`, `period_tick=0`, `busy=0`, `cfg_ready=1`;
  - cnt, active and pending registers all 0;
  - `act_vld=0`, `pend_vld=0`.
- **Reset mid-period:** the gate drops immediately (asynchronous) and all config is lost.
- **Start latency:** `en` is sampled high in IDLE at edge N, with a valid config. Then `busy=1` and `gate_out=(act_high!=0)` from edge N+1.
- **Config in IDLE:** a transfer at edge N makes the config active at edge N+1. With `en` held high, the gate starts at edge N+2.
- **Stop:** with `en` low on the wrap cycle, `busy=0` one edge after `period_tick`.
- **Back-pressure:** `cfg_ready` deasserts on the edge after a transfer. It reasserts on the edge after promotion.

## Configuration
- Macro: `GATE_PULSE_GEN_PCNT_EN`.
- **Defined:** adds output `period_count` (WIDTH bits).
  - It increments on every `period_tick` and wraps from 2^WIDTH-1 to 0.
  - It is cleared only by `rst_n`; leaving RUN does not clear it.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Shared package `gate_gen_pkg`:**
  - state encoding IDLE/RUN;
  - constant `GATE_MIN_PERIOD = 2`;
  - default `WIDTH = 32`.
- **Sub-module `gate_cfg_buf`:** the pending/active double buffer.
  - It holds the clamp logic, `pend_vld`, `act_vld` and the ready generation.
  - It takes a `promote` strobe from the FSM.
- **Top level:** FSM, cnt and output registers.

## Test plan
- **Basic waveform:** reset, transfer period=10 and high=4, `en=1`.
  - `gate_out` is high for 4 cycles and low for 6, repeating.
  - `period_tick` fires every 10 cycles, on the last low cycle.
- **Clamping:** transfer period=1, high=5.
  - Active becomes period=2, high=1: a 1-high / 1-low square wave.
  - Separately, high=0 with period=8 holds `gate_out` low while `period_tick` still fires every 8 cycles.
- **Reconfiguration while running:** running at 10/4, transfer 6/3 at cnt=2.
  - `cfg_ready` drops. The current period still finishes at 10 cycles.
  - The next period is 6/3, and `cfg_ready` returns after the wrap.
  - Repeat with the transfer exactly on the wrap cycle: the new config takes effect one full period later.
- **Stop and resume:** deassert `en` at cnt=3 of a period-10 wave.
  - The period completes, then `busy=0` and `gate_out=0`.
  - Reasserting `en` before the wrap gives continuous output with no gap.
- **Reset mid-high:** assert `rst_n=0` during the high phase.
  - `gate_out=0` and `cfg_ready=1` immediately.
  - After release, `en=1` alone does not start the block (`act_vld=0`).
- **Period counter (with `GATE_PULSE_GEN_PCNT_EN`):** run at period=2 for 5 periods.
  - `period_count` reads 5.
  - Force it to 2^WIDTH-1 and check that the next tick gives 0.
